// File: rtl/ov7670_config_ctrl.sv
// OV7670 power-up and register configuration sequencer.
// Pulses the camera hardware reset, waits for power to settle, then walks a
// small register table through an external SCCB write engine. Failed writes
// are retried a bounded number of times. After the table is done, a few frames
// are discarded before done is raised to enable capture.
module ov7670_config_ctrl #(
    parameter int unsigned CLK_HZ       = 25_000_000,
    parameter int unsigned HWRST_CYCLES = CLK_HZ / 1000,
    parameter int unsigned SWRST_CYCLES = CLK_HZ / 1000,
    parameter int unsigned SKIP_FRAMES  = 2,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       vsync,
    input  logic       sccb_ready,
    input  logic       sccb_done,
    input  logic       sccb_nack,
    output logic       sccb_req,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_data,
    output logic       cam_reset_n,
    output logic       cam_pwdn,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // ------------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------------
    localparam int unsigned MaxWait  = (HWRST_CYCLES > SWRST_CYCLES) ? HWRST_CYCLES
                                                                     : SWRST_CYCLES;
    localparam int unsigned WaitW    = (MaxWait < 1) ? 1 : $clog2(MaxWait + 1);
    localparam int unsigned RetryRaw = $clog2(MAX_RETRY + 1);
    localparam int unsigned RetryW   = (RetryRaw < 2) ? 2 : RetryRaw;
    localparam int unsigned IdxW     = 3;

    localparam logic [15:0] TermEntry = 16'hFFFF;
    localparam logic [15:0] SoftReset = 16'h1280;

    typedef enum logic [3:0] {
        StIdle,
        StHwrst,
        StPwrWait,
        StWrReq,
        StWrWait,
        StSwrstWait,
        StSkip,
        StDone,
        StError
    } state_e;

    // Register table, {address, data}; the terminator ends the walk.
    function automatic logic [15:0] tbl_entry(input logic [IdxW-1:0] idx);
        logic [15:0] e;
        case (idx)
            3'd0:    e = 16'h1280;  // COM7: soft reset
            3'd1:    e = 16'h1204;  // COM7: RGB output
            3'd2:    e = 16'h8C02;  // RGB444: enable, xR GB word order
            3'd3:    e = 16'hD0 | 16'h4000;  // COM15: full range, RGB565
            3'd4:    e = 16'h1100;  // CLKRC: no prescale
            default: e = TermEntry;
        endcase
        return e;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [7:0]        frame_q, frame_d;
    logic              skip_arm_q, skip_arm_d;
    logic              req_q, req_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              vs_meta_q, vs_sync_q, vs_prev_q;

    logic [15:0] entry;
    logic        frame_event;
    logic        hw_last;
    logic        sw_last;
    logic [7:0]  frame_inc;

    assign entry       = tbl_entry(idx_q);
    assign frame_event = vs_sync_q & ~vs_prev_q;
    assign hw_last     = (32'(wait_q) + 32'd1 >= HWRST_CYCLES);
    assign sw_last     = (32'(wait_q) + 32'd1 >= SWRST_CYCLES);
    // Frame counter saturates rather than wrapping.
    assign frame_inc   = (frame_q == 8'hFF) ? frame_q : frame_q + 8'd1;

    // vsync synchronizer plus edge-detect history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_meta_q <= vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
        end
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_q     <= '0;
            idx_q      <= '0;
            retry_q    <= '0;
            frame_q    <= '0;
            skip_arm_q <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            frame_q    <= frame_d;
            skip_arm_q <= skip_arm_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic for the sequencer
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        frame_d    = frame_q;
        skip_arm_d = skip_arm_q;
        req_d      = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start) begin
                    state_d    = StHwrst;
                    wait_d     = '0;
                    idx_d      = '0;
                    retry_d    = '0;
                    frame_d    = '0;
                    skip_arm_d = 1'b0;
                end
            end

            StHwrst: begin
                if (hw_last) begin
                    state_d = StPwrWait;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StPwrWait: begin
                if (hw_last) begin
                    state_d = StWrReq;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StWrReq: begin
                if (entry == TermEntry) begin
                    state_d    = StSkip;
                    skip_arm_d = 1'b0;
                end else if (sccb_ready) begin
                    // addr/data are latched here and held until the engine answers
                    req_d   = 1'b1;
                    addr_d  = entry[15:8];
                    data_d  = entry[7:0];
                    state_d = StWrWait;
                end
            end

            StWrWait: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        retry_d = '0;
                        idx_d   = idx_q + 1'b1;
                        if ({addr_q, data_q} == SoftReset) begin
                            state_d = StSwrstWait;
                            wait_d  = '0;
                        end else begin
                            state_d = StWrReq;
                        end
                    end else if (32'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + 1'b1;
                        state_d = StWrReq;
                    end else begin
                        state_d = StError;
                    end
                end
            end

            StSwrstWait: begin
                if (sw_last) begin
                    state_d = StWrReq;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StSkip: begin
                // The first SKIP cycle only arms the counter so a stale edge
                // coinciding with entry is not taken as a frame.
                skip_arm_d = 1'b1;
                if (32'(frame_q) >= SKIP_FRAMES) begin
                    state_d = StDone;
                end else if (frame_event && skip_arm_q) begin
                    frame_d = frame_inc;
                    if (32'(frame_inc) >= SKIP_FRAMES) begin
                        state_d = StDone;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state and registered datapath
    always_comb begin
        sccb_req    = req_q;
        sccb_addr   = addr_q;
        sccb_data   = data_q;
        cam_reset_n = (state_q != StHwrst);
        // Power-down is only held after reset, before the first start.
        cam_pwdn    = (state_q == StIdle);
        busy        = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
        done        = (state_q == StDone);
        error       = (state_q == StError);
    end

endmodule

// File: doc/ov7670_config_ctrl.md
OV7670_CONFIG_CTRL -- requirements
Module: ov7670_config_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 25_000_000, system clock frequency used to derive wait counts.
REQ-002 Parameter HWRST_CYCLES, default CLK_HZ/1000, duration of cam_reset_n low (1 ms) and of the post-release power wait.
REQ-003 Parameter SWRST_CYCLES, default CLK_HZ/1000, wait after the soft-reset write (COM7=0x80).
REQ-004 Parameter SKIP_FRAMES, default 2, frames discarded after configuration before done asserts.
REQ-005 Parameter MAX_RETRY, default 3, re-attempts per register write after a NACK.
REQ-006 clk  in  1  system clock; every flop is clocked on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous and active-low.
REQ-008 start  in  1  one-cycle pulse that begins or restarts the configuration sequence.
REQ-009 vsync  in  1  camera vertical sync, asynchronous to clk.
REQ-010 sccb_ready  in  1  SCCB write engine idle and able to accept a request.
REQ-011 sccb_done  in  1  one-cycle pulse marking the end of the current write.
REQ-012 sccb_nack  in  1  qualifies sccb_done: the write failed.
REQ-013 sccb_req  out  1  one-cycle write request pulse.
REQ-014 sccb_addr  out  8  OV7670 register address; held stable from sccb_req until sccb_done.
REQ-015 sccb_data  out  8  register write data; held stable from sccb_req until sccb_done.
REQ-016 cam_reset_n  out  1  camera hardware reset, active-low.
REQ-017 cam_pwdn  out  1  camera power-down, active-high.
REQ-018 busy  out  1  sequence in progress: any state other than IDLE, DONE or ERROR.
REQ-019 done  out  1  camera configured and SKIP_FRAMES frames skipped; enables frame capture.
REQ-020 error  out  1  configuration aborted after retries were exhausted.

Function
REQ-021 vsync shall pass through a 2-flop synchronizer; a frame event shall be a synchronized 0->1 transition.
REQ-022 The internal table shall contain, in order: (0x12,0x80) (0x12,0x04) (0x8C,0x02) (0x40,0xD0) (0x11,0x00), followed by terminator (0xFF,0xFF).
REQ-023 States: IDLE, HWRST, PWR_WAIT, WR_REQ, WR_WAIT, SWRST_WAIT, SKIP, DONE, ERROR.
REQ-024 IDLE/DONE/ERROR on start: go to HWRST; clear table index, retry count, frame count, done and error.
REQ-025 start in any other state shall be ignored.
REQ-026 HWRST: cam_reset_n=0 for HWRST_CYCLES cycles, then release it and go to PWR_WAIT.
REQ-027 PWR_WAIT: wait HWRST_CYCLES cycles, then go to WR_REQ.
REQ-028 WR_REQ: if the current entry is the terminator, go to SKIP; otherwise wait for sccb_ready=1, pulse sccb_req for exactly 1 cycle, and go to WR_WAIT.
REQ-029 WR_WAIT, on sccb_done with sccb_nack=0: clear retry count and advance index.
REQ-030 If that completed write was (0x12,0x80), go to SWRST_WAIT; otherwise go to WR_REQ.
REQ-031 WR_WAIT, on sccb_done with sccb_nack=1: if retry count < MAX_RETRY, increment it and return to WR_REQ with the same index.
REQ-032 Otherwise go to ERROR with error=1.
REQ-033 SWRST_WAIT: wait SWRST_CYCLES cycles, then go to WR_REQ.
REQ-034 SKIP: count frame events; when the count reaches SKIP_FRAMES, go to DONE with done=1.
REQ-035 With SKIP_FRAMES=0, SKIP shall exit to DONE on the next cycle.
REQ-036 A frame event in the same cycle as SKIP entry shall not be counted.
REQ-037 DONE: done stays 1 until start or reset; ERROR: error stays 1 until start or reset.
REQ-038 cam_pwdn shall be 0 in every state except IDLE after reset, where it is 1; cam_pwdn drops to 0 on HWRST entry.
REQ-039 Wait counters shall be sized ceil(log2(max wait + 1)); the retry count is 2 bits minimum; the frame count is 8 bits and saturates.
REQ-040 sccb_done outside WR_WAIT shall be ignored.

Reset
REQ-041 Reset values: state=IDLE, sccb_req=0, sccb_addr=0, sccb_data=0, cam_reset_n=1, cam_pwdn=1, busy=0, done=0, error=0; all counters 0.
REQ-042 rst_n low mid-sequence, including WR_WAIT, shall return the block to IDLE with reset values on the next clock edge; the outstanding write is abandoned.

Verification (HWRST_CYCLES=SWRST_CYCLES=10, SKIP_FRAMES=2)
REQ-043 Nominal: start pulse, engine always ACKs in 4 cycles -> cam_reset_n low exactly 10 cycles; 5 sccb_req pulses with addr/data 12/80, 12/04, 8C/02, 40/D0, 11/00; a ≥10-cycle gap after the first write; done=1 after the 2nd vsync rise.
REQ-044 NACK recovery: 3rd write NACKed twice, then ACKed -> 3 requests to 0x8C/0x02; done eventually 1; error=0.
REQ-045 Retry exhaustion: 2nd write always NACKed -> 4 requests total for 0x12/0x04; error=1; busy=0; no further sccb_req pulses.
REQ-046 Restart: start in ERROR -> error clears; full sequence repeats from HWRST. A start pulse during WR_WAIT changes nothing.
REQ-047 Mid-operation reset: rst_n low during WR_WAIT -> next edge gives state IDLE, cam_pwdn=1, all outputs at reset values; a late sccb_done is ignored.
REQ-048 Frame skip: vsync toggling before SKIP produces no count; vsync pulses shorter than 2 clk cycles are not required to count; done rises 3 cycles after the synchronized 2nd edge at most.
